branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
// Parametrised branch/jump resolution unit for the multi-cycle RV32 core. Evaluates all six RV32I
// conditional branches plus JAL/JALR in a configurable stage, computes and registers the target,
// and hands a PC redirect to fetch over a valid/ready handshake. Also flags misaligned targets and
// illegal funct3 encodings, and keeps saturating branch statistics.
// PARAMETERS
// XLEN        32  datapath width of operands, PC and target
// STAGE_W     2   width of the stage counter input
// EVAL_STAGE  2   stage value in which operands are sampled and the condition is evaluated
// CNT_W       16  width of the saturating statistics counters
// PORTS
// clk               in   1        core clock; all state updates on the rising edge
// rst_n             in   1        asynchronous, active-low reset
// stage             in   STAGE_W  current stage of the multi-cycle sequencer
// branch_instruction in  1        current instruction is a conditional branch (opcode BRANCH)
// jal / jalr        in   1 / 1    current instruction is JAL / JALR (mutually exclusive with branch)
// funct3            in   3        branch condition select
// bus_rs1, bus_rs2  in   XLEN     register operands
// pc, imm           in   XLEN     instruction PC and sign-extended immediate
// redirect_ready    in   1        fetch accepts the redirect this cycle
// redirect_valid    out  1        redirect_pc is valid; held until accepted
// redirect_pc       out  XLEN     resolved target
// branch_enable     out  1        registered taken decision of the last resolved instruction
// busy              out  1        unit is holding an unaccepted redirect; sequencer must stall
// misalign_exc      out  1        one-cycle pulse: taken target has bit[1] set (IALIGN=32)
// illegal_exc       out  1        one-cycle pulse: branch with funct3 = 3'b010 or 3'b011
// branch_count, taken_count out CNT_W  resolved / taken control transfers, saturating
// BEHAVIOUR
// - Reset: state IDLE; every output 0, including redirect_pc and both counters.
// - States: IDLE, REDIRECT. Evaluation request = (stage == EVAL_STAGE) & (branch_instruction | jal | jalr).
// - IDLE + request, one-cycle latency: register the decision and target on that edge.
//   funct3: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU. jal/jalr always taken.
//   Target: pc+imm for branch/JAL; (rs1+imm) & ~1 for JALR; all sums XLEN-bit modulo 2^XLEN (wrap).
// - Taken, target[1]==0: branch_enable<=1, redirect_valid<=1, go REDIRECT.
// - Taken, target[1]==1: misalign_exc pulses, branch_enable<=0, no redirect, stay IDLE.
// - Illegal funct3: illegal_exc pulses, branch_enable<=0, no redirect, counters untouched.
// - Not taken: branch_enable<=0, stay IDLE.
// - REDIRECT: redirect_valid and redirect_pc held stable, busy=1; on redirect_ready go IDLE, drop valid.
// - A request arriving in REDIRECT is ignored (sequencer stalls on busy). A request in the accept
//   cycle is also ignored; the first new request is taken the cycle after.
// - Request while stage != EVAL_STAGE: ignored. Operands are sampled only in EVAL_STAGE.
// - branch_enable holds its value until the next resolved request.
// - Counters: branch_count += 1 per legal resolved request; taken_count += 1 per issued redirect;
//   both saturate at all-ones and do not wrap.
// - Reset asserted mid-REDIRECT: the redirect is dropped immediately and redirect_valid goes 0 asynchronously.
// STRUCTURE
// - Shared package: funct3 condition encodings, FSM state encoding, IALIGN mask constant.
// - One sub-module, branch_compare: combinational XLEN-wide EQ/LT/LTU compare -> taken; the
//   top level holds the FSM, target adder, exception pulses and counters.
// TESTING
// 1 BEQ rs1=rs2=5, pc=0x100, imm=0x20 in EVAL_STAGE -> next cycle redirect_valid=1, pc=0x120, enable=1.
// 2 BLT rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU with same operands -> not taken, no redirect, enable=0.
// 3 JALR rs1=0x1003, imm=0 -> target 0x1002 -> misalign_exc pulse, no redirect; imm=1 -> 0x1004 redirected.
// 4 redirect_ready=0 for 3 cycles, new request injected -> valid/pc stable, busy=1, request ignored.
// 5 funct3=3'b010 with branch_instruction -> illegal_exc pulse, counters unchanged; pc=0xFFFFFFF0, imm=0x20 -> 0x10.
// 6 rst_n low during REDIRECT -> all outputs 0 at once; counters preloaded near all-ones saturate, no wrap.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the branch resolution unit: branch conditions, FSM states and the
// target-alignment constant.
package branch_resolve_unit_pkg;

    // RV32I conditional branch funct3 encodings (3'b010 / 3'b011 are reserved).
    typedef enum logic [2:0] {
        F3Beq  = 3'b000,
        F3Bne  = 3'b001,
        F3Blt  = 3'b100,
        F3Bge  = 3'b101,
        F3Bltu = 3'b110,
        F3Bgeu = 3'b111
    } funct3_e;

    typedef enum logic {
        StIdle     = 1'b0,
        StRedirect = 1'b1
    } bru_state_e;

    // With IALIGN=32 a target is misaligned when this bit is set (bit 0 is never set here).
    localparam int unsigned IalignMisalignBit = 1;

    // Reserved branch encodings are 3'b010 and 3'b011.
    function automatic logic funct3_illegal(input logic [2:0] funct3);
        return funct3[2:1] == 2'b01;
    endfunction

endpackage

// File: rtl/branch_compare.sv
// Combinational XLEN-wide branch condition evaluation (EQ/NE/LT/GE/LTU/GEU).
module branch_compare
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            taken_o
);

    logic eq;
    logic lt;
    logic ltu;

    assign eq  = (rs1_i == rs2_i);
    assign lt  = ($signed(rs1_i) < $signed(rs2_i));
    assign ltu = (rs1_i < rs2_i);

    // Select the condition; reserved encodings never report taken.
    always_comb begin
        taken_o = 1'b0;
        unique case (funct3_e'(funct3_i))
            F3Beq:   taken_o = eq;
            F3Bne:   taken_o = ~eq;
            F3Blt:   taken_o = lt;
            F3Bge:   taken_o = ~lt;
            F3Bltu:  taken_o = ltu;
            F3Bgeu:  taken_o = ~ltu;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution for the multi-cycle RV32 core: evaluates the condition in the
// configured stage, registers the target and offers a PC redirect to fetch until accepted.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned STAGE_W    = 2,
    parameter int unsigned EVAL_STAGE = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [STAGE_W-1:0] stage_i,
    input  logic               branch_instruction_i,
    input  logic               jal_i,
    input  logic               jalr_i,
    input  logic [2:0]         funct3_i,
    input  logic [XLEN-1:0]    bus_rs1_i,
    input  logic [XLEN-1:0]    bus_rs2_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [XLEN-1:0]    imm_i,
    input  logic               redirect_ready_i,
    output logic               redirect_valid_o,
    output logic [XLEN-1:0]    redirect_pc_o,
    output logic               branch_enable_o,
    output logic               busy_o,
    output logic               misalign_exc_o,
    output logic               illegal_exc_o,
    output logic [CNT_W-1:0]   branch_count_o,
    output logic [CNT_W-1:0]   taken_count_o
);

    bru_state_e       state_q;
    logic             redirect_valid_q;
    logic [XLEN-1:0]  redirect_pc_q;
    logic             branch_enable_q;
    logic             misalign_q;
    logic             illegal_q;
    logic [CNT_W-1:0] branch_count_q;
    logic [CNT_W-1:0] taken_count_q;

    logic             request;
    logic             cond_taken;
    logic             illegal;
    logic             taken;
    logic [XLEN-1:0]  sum_base;
    logic [XLEN-1:0]  target_sum;
    logic [XLEN-1:0]  target_d;

    assign request = (stage_i == STAGE_W'(EVAL_STAGE))
                   & (branch_instruction_i | jal_i | jalr_i);

    branch_compare #(
        .XLEN(XLEN)
    ) u_branch_compare (
        .funct3_i(funct3_i),
        .rs1_i   (bus_rs1_i),
        .rs2_i   (bus_rs2_i),
        .taken_o (cond_taken)
    );

    // Jumps ignore funct3; only a conditional branch can carry a reserved encoding.
    assign illegal = branch_instruction_i & ~jal_i & ~jalr_i & funct3_illegal(funct3_i);
    assign taken   = jal_i | jalr_i | (branch_instruction_i & cond_taken);

    // Target adder: pc+imm, or (rs1+imm) with bit 0 cleared for JALR; wraps modulo 2^XLEN.
    always_comb begin
        sum_base   = jalr_i ? bus_rs1_i : pc_i;
        target_sum = sum_base + imm_i;
        target_d   = jalr_i ? {target_sum[XLEN-1:1], 1'b0} : target_sum;
    end

    // Redirect FSM with registered outputs, exception pulses and saturating statistics.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= StIdle;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            branch_enable_q  <= 1'b0;
            misalign_q       <= 1'b0;
            illegal_q        <= 1'b0;
            branch_count_q   <= '0;
            taken_count_q    <= '0;
        end else begin
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (request) begin
                        if (illegal) begin
                            illegal_q       <= 1'b1;
                            branch_enable_q <= 1'b0;
                        end else begin
                            if (~&branch_count_q) begin
                                branch_count_q <= branch_count_q + CNT_W'(1);
                            end
                            if (taken && target_d[IalignMisalignBit]) begin
                                misalign_q      <= 1'b1;
                                branch_enable_q <= 1'b0;
                            end else if (taken) begin
                                branch_enable_q  <= 1'b1;
                                redirect_valid_q <= 1'b1;
                                redirect_pc_q    <= target_d;
                                state_q          <= StRedirect;
                                if (~&taken_count_q) begin
                                    taken_count_q <= taken_count_q + CNT_W'(1);
                                end
                            end else begin
                                branch_enable_q <= 1'b0;
                            end
                        end
                    end
                end
                StRedirect: begin
                    // New requests are ignored here, including in the accept cycle.
                    if (redirect_ready_i) begin
                        redirect_valid_q <= 1'b0;
                        state_q          <= StIdle;
                    end
                end
                default: begin
                    redirect_valid_q <= 1'b0;
                    state_q          <= StIdle;
                end
            endcase
        end
    end

    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign branch_enable_o  = branch_enable_q;
    assign busy_o           = redirect_valid_q;
    assign misalign_exc_o   = misalign_q;
    assign illegal_exc_o    = illegal_q;
    assign branch_count_o   = branch_count_q;
    assign taken_count_o    = taken_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: a vector table plus hand-written sequences for
// stalls, stage gating, counter saturation and asynchronous reset.
module tb_branch_resolve_unit;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned STAGE_W = 2;
    localparam int unsigned EVAL    = 2;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst_n;
    logic [STAGE_W-1:0] stage;
    logic               br;
    logic               jal;
    logic               jalr;
    logic [2:0]         f3;
    logic [XLEN-1:0]    rs1;
    logic [XLEN-1:0]    rs2;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    imm;
    logic               ready;
    logic               valid_o;
    logic [XLEN-1:0]    rpc_o;
    logic               en_o;
    logic               busy_o;
    logic               mis_o;
    logic               ill_o;
    logic [CNT_W-1:0]   bc_o;
    logic [CNT_W-1:0]   tc_o;

    branch_resolve_unit #(
        .XLEN      (XLEN),
        .STAGE_W   (STAGE_W),
        .EVAL_STAGE(EVAL),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .stage_i             (stage),
        .branch_instruction_i(br),
        .jal_i               (jal),
        .jalr_i              (jalr),
        .funct3_i            (f3),
        .bus_rs1_i           (rs1),
        .bus_rs2_i           (rs2),
        .pc_i                (pc),
        .imm_i               (imm),
        .redirect_ready_i    (ready),
        .redirect_valid_o    (valid_o),
        .redirect_pc_o       (rpc_o),
        .branch_enable_o     (en_o),
        .busy_o              (busy_o),
        .misalign_exc_o      (mis_o),
        .illegal_exc_o       (ill_o),
        .branch_count_o      (bc_o),
        .taken_count_o       (tc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        br;
        logic        jal;
        logic        jalr;
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_en;
        logic        exp_mis;
        logic        exp_ill;
    } vec_t;

    vec_t        vec[13];
    logic [31:0] sb_q[$];
    int          total;
    int          passed;
    int          exp_bc;
    int          exp_tc;

    function automatic vec_t mk(input logic b, input logic j, input logic jr, input logic [2:0] f,
                                input logic [31:0] a, input logic [31:0] c, input logic [31:0] p,
                                input logic [31:0] i, input logic v, input logic [31:0] ep,
                                input logic e, input logic m, input logic il);
        vec_t r;
        r.br = b; r.jal = j; r.jalr = jr; r.f3 = f; r.rs1 = a; r.rs2 = c; r.pc = p; r.imm = i;
        r.exp_valid = v; r.exp_pc = ep; r.exp_en = e; r.exp_mis = m; r.exp_ill = il;
        return r;
    endfunction

    function automatic int bump(input int c);
        return (c >= CNT_MAX) ? CNT_MAX : c + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        br = 1'b0; jal = 1'b0; jalr = 1'b0; stage = '0;
    endtask

    task automatic drive(input logic b, input logic j, input logic jr, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] c, input logic [31:0] p,
                         input logic [31:0] i, input logic [STAGE_W-1:0] st);
        br = b; jal = j; jalr = jr; f3 = f; rs1 = a; rs2 = c; pc = p; imm = i; stage = st;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_branch_count"}, 32'(bc_o), 32'(exp_bc));
        chk({tag, "_taken_count"}, 32'(tc_o), 32'(exp_tc));
    endtask

    // Accept the pending redirect, comparing its target against the scoreboard head.
    task automatic accept();
        logic [31:0] exp_pc;
        chk("accept_valid_before", 32'(valid_o), 32'd1);
        if (sb_q.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            exp_pc = sb_q.pop_front();
            chk("redirect_pc", rpc_o, exp_pc);
        end
        clear_req();
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("accept_valid_after", 32'(valid_o), 32'd0);
        chk("accept_busy_after", 32'(busy_o), 32'd0);
    endtask

    // Issue a JAL that is expected to redirect, updating the model.
    task automatic issue_jal(input logic [31:0] p, input logic [31:0] i);
        drive(1'b0, 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, p, i, STAGE_W'(EVAL));
        sb_q.push_back(p + i);
        exp_bc = bump(exp_bc);
        exp_tc = bump(exp_tc);
        step();
        clear_req();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0; passed = 0; exp_bc = 0; exp_tc = 0;
        rst_n = 1'b0; ready = 1'b0;
        f3 = '0; rs1 = '0; rs2 = '0; pc = '0; imm = '0;
        clear_req();

        vec[0]  = mk(1, 0, 0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1, 32'h120, 1, 0, 0);
        vec[1]  = mk(1, 0, 0, 3'b100, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h8, 1, 32'h208, 1, 0, 0);
        vec[2]  = mk(1, 0, 0, 3'b110, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h8, 0, 32'h0, 0, 0, 0);
        vec[3]  = mk(1, 0, 0, 3'b001, 32'd3, 32'd3, 32'h240, 32'h8, 0, 32'h0, 0, 0, 0);
        vec[4]  = mk(1, 0, 0, 3'b101, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'h300, 32'hFFFFFFFC,
                     1, 32'h2FC, 1, 0, 0);
        vec[5]  = mk(1, 0, 0, 3'b111, 32'd1, 32'hFFFFFFFF, 32'h300, 32'h8, 0, 32'h0, 0, 0, 0);
        vec[6]  = mk(0, 1, 0, 3'b000, 32'd0, 32'd0, 32'h400, 32'h10, 1, 32'h410, 1, 0, 0);
        vec[7]  = mk(0, 0, 1, 3'b000, 32'h1003, 32'd0, 32'h600, 32'h0, 0, 32'h0, 0, 1, 0);
        vec[8]  = mk(0, 0, 1, 3'b000, 32'h1003, 32'd0, 32'h600, 32'h1, 1, 32'h1004, 1, 0, 0);
        vec[9]  = mk(1, 0, 0, 3'b010, 32'd5, 32'd5, 32'h700, 32'h20, 0, 32'h0, 0, 0, 1);
        vec[10] = mk(1, 0, 0, 3'b011, 32'd5, 32'd6, 32'h700, 32'h20, 0, 32'h0, 0, 0, 1);
        vec[11] = mk(1, 0, 0, 3'b000, 32'd7, 32'd7, 32'hFFFFFFF0, 32'h20, 1, 32'h10, 1, 0, 0);
        vec[12] = mk(1, 0, 0, 3'b000, 32'd7, 32'd7, 32'h100, 32'h2, 0, 32'h0, 0, 1, 0);

        // Reset state.
        step();
        step();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_pc", rpc_o, 32'd0);
        chk("rst_enable", 32'(en_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk_counts("rst");
        rst_n = 1'b1;
        step();

        // Table-driven vectors.
        for (int i = 0; i < 13; i++) begin
            drive(vec[i].br, vec[i].jal, vec[i].jalr, vec[i].f3, vec[i].rs1, vec[i].rs2,
                  vec[i].pc, vec[i].imm, STAGE_W'(EVAL));
            if (vec[i].exp_valid) sb_q.push_back(vec[i].exp_pc);
            if (!vec[i].exp_ill) exp_bc = bump(exp_bc);
            if (vec[i].exp_valid) exp_tc = bump(exp_tc);
            step();
            clear_req();
            chk($sformatf("v%0d_valid", i), 32'(valid_o), 32'(vec[i].exp_valid));
            chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'(vec[i].exp_valid));
            chk($sformatf("v%0d_enable", i), 32'(en_o), 32'(vec[i].exp_en));
            chk($sformatf("v%0d_misalign", i), 32'(mis_o), 32'(vec[i].exp_mis));
            chk($sformatf("v%0d_illegal", i), 32'(ill_o), 32'(vec[i].exp_ill));
            chk_counts($sformatf("v%0d", i));
            if (vec[i].exp_valid) begin
                accept();
            end else begin
                step();
                chk($sformatf("v%0d_mis_pulse_end", i), 32'(mis_o), 32'd0);
                chk($sformatf("v%0d_ill_pulse_end", i), 32'(ill_o), 32'd0);
            end
            chk($sformatf("v%0d_enable_hold", i), 32'(en_o), 32'(vec[i].exp_en));
        end

        // Stall: redirect held for 3 cycles while new requests are ignored.
        issue_jal(32'h500, 32'h20);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd9, 32'd9, 32'h800, 32'h0, STAGE_W'(EVAL));
            step();
            chk($sformatf("stall%0d_valid", k), 32'(valid_o), 32'd1);
            chk($sformatf("stall%0d_pc", k), rpc_o, 32'h520);
            chk($sformatf("stall%0d_busy", k), 32'(busy_o), 32'd1);
            chk_counts($sformatf("stall%0d", k));
        end
        // Accept cycle with a request present: that request is dropped.
        chk("acc_pc", rpc_o, sb_q.pop_front());
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("acc_valid", 32'(valid_o), 32'd0);
        chk_counts("acc");
        // Request still present the cycle after: now taken.
        sb_q.push_back(32'h800);
        exp_bc = bump(exp_bc);
        exp_tc = bump(exp_tc);
        step();
        clear_req();
        chk("post_acc_valid", 32'(valid_o), 32'd1);
        chk_counts("post_acc");
        accept();

        // Requests outside the evaluation stage are ignored.
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'd1, 32'd1, 32'h900, 32'h4, STAGE_W'(1));
        step();
        chk("stage1_valid", 32'(valid_o), 32'd0);
        drive(0, 1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 32'h900, 32'h4, STAGE_W'(3));
        step();
        chk("stage3_valid", 32'(valid_o), 32'd0);
        chk_counts("stage_gate");
        clear_req();

        // Saturation: push both counters past all-ones.
        for (int k = 0; k < 9; k++) begin
            issue_jal(32'hA00 + 32'(k * 16), 32'h8);
            accept();
        end
        chk("sat_branch_count", 32'(bc_o), 32'(CNT_MAX));
        chk("sat_taken_count", 32'(tc_o), 32'(CNT_MAX));

        // Reset asserted mid-redirect clears everything without a clock edge.
        issue_jal(32'hB00, 32'h8);
        chk("prerst_valid", 32'(valid_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(valid_o), 32'd0);
        chk("arst_pc", rpc_o, 32'd0);
        chk("arst_enable", 32'(en_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_branch_count", 32'(bc_o), 32'd0);
        chk("arst_taken_count", 32'(tc_o), 32'd0);
        sb_q.delete();
        exp_bc = 0;
        exp_tc = 0;
        step();
        rst_n = 1'b1;
        step();
        issue_jal(32'hC00, 32'h4);
        chk("recover_valid", 32'(valid_o), 32'd1);
        chk_counts("recover");
        accept();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
